snn_multi_layer_sequencer: RTL and testbench

- Top-level inference sequencer for the bin-ratio ensemble SNN.
- Requests a sample, then counts NUM_STEPS timesteps internally; no external steps_done input.
- Steps through NUM_LAYERS layer stages whenever a timestep carries spikes, then triggers one winner-takes-all read and returns to request.
- Successor of the two-layer inter-layer controller:
  - parametrised step count and layer depth
  - explicit step handshake
  - single-pulse control outputs
  - optional watchdog

---
 rtl/snn_seq_pkg.sv | 22 ++
 rtl/snn_seq_watchdog.sv | 28 ++
 rtl/snn_multi_layer_sequencer.sv | 148 ++++++++++++++
 tb/tb_snn_multi_layer_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_seq_pkg.sv
// Shared state encoding, default sizing and width helper for the multi-layer SNN sequencer.
// Optional watchdog is enabled in the top with `define SNN_SEQ_WATCHDOG_EN.
package snn_seq_pkg;

  localparam int DEFAULT_NUM_LAYERS     = 2;
  localparam int DEFAULT_NUM_STEPS      = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    REQUEST = 3'd0,
    SPK_GEN = 3'd1,
    LAYER   = 3'd2,
    WTA     = 3'd3,
    DONE    = 3'd4
  } seq_state_e;

  // Index width for a counter over n values, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snn_seq_watchdog.sv
// Per-state cycle counter for the sequencer; flags expiry once a waiting state
// has lasted TIMEOUT_CYCLES cycles. Only instantiated with SNN_SEQ_WATCHDOG_EN.
module snn_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Fires in the TIMEOUT_CYCLES-th counted cycle so the FSM leaves on that edge.
  assign expired = enable && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/snn_multi_layer_sequencer.sv
// Inference sequencer: request sample, run NUM_STEPS timesteps through NUM_LAYERS
// layer stages on spiking steps, then one WTA read. Watchdog via SNN_SEQ_WATCHDOG_EN.
module snn_multi_layer_sequencer
  import snn_seq_pkg::*;
#(
  parameter int NUM_LAYERS     = DEFAULT_NUM_LAYERS,
  parameter int NUM_STEPS      = DEFAULT_NUM_STEPS,
  parameter int STEP_W         = idx_width(NUM_STEPS),
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trans_start,
  input  logic                  step_valid,
  input  logic                  spk_in,
  input  logic                  layer_done,
  input  logic                  infer_ready,
  output logic                  rqt_new_sample,
  output logic                  step_ready,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic [STEP_W-1:0]     step_cnt,
  output logic                  get_winner,
  output logic                  sample_done,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int LIDX_W = idx_width(NUM_LAYERS);
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(NUM_STEPS - 1);
  localparam logic [LIDX_W-1:0] LAST_LAYER = LIDX_W'(NUM_LAYERS - 1);

  seq_state_e            state, state_next;
  logic [STEP_W-1:0]     step_cnt_next;
  logic [LIDX_W-1:0]     layer_idx, layer_idx_next;
  logic [NUM_LAYERS-1:0] layer_start_next;
  logic                  step_end;
  logic                  expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQUEST;
      step_cnt    <= '0;
      layer_idx   <= '0;
      layer_start <= '0;
      get_winner  <= 1'b0;
    end else begin
      state       <= state_next;
      step_cnt    <= step_cnt_next;
      layer_idx   <= layer_idx_next;
      layer_start <= layer_start_next;
      get_winner  <= (state_next == WTA) && (state != WTA);
    end
  end

  // Pulses are computed from the next state so a watchdog abort suppresses them.
  always_comb begin
    state_next       = state;
    step_cnt_next    = step_cnt;
    layer_idx_next   = layer_idx;
    layer_start_next = '0;
    step_end         = 1'b0;

    case (state)
      REQUEST: begin
        if (trans_start) begin
          state_next    = SPK_GEN;
          step_cnt_next = '0;
        end
      end
      SPK_GEN: begin
        if (step_valid) begin
          if (spk_in) begin
            state_next       = LAYER;
            layer_idx_next   = '0;
            layer_start_next = NUM_LAYERS'(1);
          end else begin
            step_end = 1'b1;
          end
        end
      end
      LAYER: begin
        if (layer_done) begin
          if (layer_idx != LAST_LAYER) begin
            layer_idx_next   = layer_idx + LIDX_W'(1);
            layer_start_next = NUM_LAYERS'(1) << (layer_idx + LIDX_W'(1));
          end else begin
            step_end = 1'b1;
          end
        end
      end
      WTA: begin
        if (infer_ready) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = REQUEST;
      default: state_next = REQUEST;
    endcase

    if (step_end) begin
      if (step_cnt == LAST_STEP) begin
        state_next = WTA;
      end else begin
        step_cnt_next = step_cnt + STEP_W'(1);
        state_next    = SPK_GEN;
      end
    end

    if (expired) begin
      state_next       = REQUEST;
      layer_start_next = '0;
    end
  end

  assign rqt_new_sample = (state == REQUEST);
  assign step_ready     = (state == SPK_GEN);
  assign sample_done    = (state == DONE);
  assign busy           = (state != REQUEST);

`ifdef SNN_SEQ_WATCHDOG_EN
  logic wd_clear, wd_enable;

  assign wd_clear  = (state_next != state);
  assign wd_enable = (state == LAYER) || (state == WTA);

  snn_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (expired) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_snn_multi_layer_sequencer.sv
// Self-checking bench for snn_multi_layer_sequencer: randomized samples against a
// transaction-level timeline model, plus directed reset and watchdog scenarios.
module tb_snn_multi_layer_sequencer;

  localparam int NL = 2;
  localparam int NS = 4;
  localparam int SW = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          trans_start, step_valid, spk_in, layer_done, infer_ready;
  logic          rqt_new_sample, step_ready, get_winner, sample_done, busy, timeout_err;
  logic [NL-1:0] layer_start;
  logic [SW-1:0] step_cnt;

  int checks   = 0;
  int failures = 0;
  int ls_count [NL];
  int gw_count, sd_count, hot_err;

  always #5 clk = ~clk;

  snn_multi_layer_sequencer #(
    .NUM_LAYERS    (NL),
    .NUM_STEPS     (NS),
    .STEP_W        (SW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .trans_start   (trans_start),
    .step_valid    (step_valid),
    .spk_in        (spk_in),
    .layer_done    (layer_done),
    .infer_ready   (infer_ready),
    .rqt_new_sample(rqt_new_sample),
    .step_ready    (step_ready),
    .layer_start   (layer_start),
    .step_cnt      (step_cnt),
    .get_winner    (get_winner),
    .sample_done   (sample_done),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance to the next falling edge and tally pulses seen in that cycle.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < NL; i++) if (layer_start[i]) ls_count[i]++;
      if ($countones(layer_start) > 1) hot_err++;
      if (get_winner) gw_count++;
      if (sample_done) sd_count++;
    end
  endtask

  task automatic clearCounts();
    for (int i = 0; i < NL; i++) ls_count[i] = 0;
    gw_count = 0;
    sd_count = 0;
    hot_err  = 0;
  endtask

  // One full sample; caller is at a falling edge with the DUT in REQUEST.
  task automatic applyStimulus(input logic [NS-1:0] spk, input bit hold_valid, input bit hold_infer);
    int d, w;
    clearCounts();
    checkOutput("req_rqt", rqt_new_sample, 1);
    checkOutput("req_busy", busy, 0);
    trans_start = 1'b1;
    tick();
    trans_start = 1'b0;
    for (int s = 0; s < NS; s++) begin
      checkOutput("spk_ready", step_ready, 1);
      checkOutput("spk_step_cnt", step_cnt, s);
      checkOutput("spk_no_ls", layer_start, 0);
      if (!hold_valid) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          checkOutput("gap_step_cnt", step_cnt, s);
        end
      end
      step_valid = 1'b1;
      spk_in     = spk[s];
      tick();
      if (!hold_valid) step_valid = 1'b0;
      if (spk[s]) begin
        for (int l = 0; l < NL; l++) begin
          checkOutput("ls_pulse", layer_start, 1 << l);
          checkOutput("layer_step_cnt", step_cnt, s);
          checkOutput("layer_not_ready", step_ready, 0);
          d = $urandom_range(0, 3);
          layer_done = (d == 0);
          for (int k = 1; k <= d; k++) begin
            tick();
            checkOutput("ls_idle", layer_start, 0);
            checkOutput("layer_hold_cnt", step_cnt, s);
            layer_done = (k == d);
          end
          tick();
          layer_done = 1'b0;
        end
      end
    end
    checkOutput("wta_gw", get_winner, 1);
    checkOutput("wta_busy", busy, 1);
    checkOutput("wta_not_ready", step_ready, 0);
    w = $urandom_range(0, 4);
    infer_ready = (w == 0);
    for (int k = 1; k <= w; k++) begin
      tick();
      checkOutput("wta_gw_once", get_winner, 0);
      checkOutput("wta_no_sd", sample_done, 0);
      infer_ready = (k == w);
    end
    tick();
    checkOutput("done_sd", sample_done, 1);
    checkOutput("done_gw", get_winner, 0);
    checkOutput("done_busy", busy, 1);
    if (!hold_infer) infer_ready = 1'b0;
    step_valid = 1'b0;
    tick();
    checkOutput("back_rqt", rqt_new_sample, 1);
    checkOutput("back_sd", sample_done, 0);
    if (hold_infer) begin
      repeat (3) begin
        tick();
        checkOutput("hold_rqt", rqt_new_sample, 1);
        checkOutput("hold_sd", sample_done, 0);
      end
      infer_ready = 1'b0;
    end
    for (int i = 0; i < NL; i++) checkOutput("ls_total", ls_count[i], $countones(spk));
    checkOutput("gw_total", gw_count, 1);
    checkOutput("sd_total", sd_count, 1);
    checkOutput("onehot", hot_err, 0);
    checkOutput("tmo_clear", timeout_err, 0);
  endtask

  task automatic resetMidLayer();
    trans_start = 1'b1;
    tick();
    trans_start = 1'b0;
    step_valid  = 1'b1;
    spk_in      = 1'b0;
    tick();
    tick();
    spk_in = 1'b1;
    tick();
    step_valid = 1'b0;
    checkOutput("rst_pre_ls", layer_start, 1);
    checkOutput("rst_pre_cnt", step_cnt, 2);
    tick();
    rst        = 1'b1;
    layer_done = 1'b1;
    tick();
    checkOutput("rst_rqt", rqt_new_sample, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cnt", step_cnt, 0);
    checkOutput("rst_ls", layer_start, 0);
    checkOutput("rst_gw", get_winner, 0);
    checkOutput("rst_sd", sample_done, 0);
    rst        = 1'b0;
    layer_done = 1'b0;
    tick();
    checkOutput("rst_after_ls", layer_start, 0);
  endtask

`ifdef SNN_SEQ_WATCHDOG_EN
  task automatic watchdogCase();
    clearCounts();
    trans_start = 1'b1;
    tick();
    trans_start = 1'b0;
    step_valid  = 1'b1;
    spk_in      = 1'b1;
    tick();
    step_valid = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      checkOutput("wd_in_layer", busy, 1);
      checkOutput("wd_no_err", timeout_err, 0);
      tick();
    end
    checkOutput("wd_err", timeout_err, 1);
    checkOutput("wd_rqt", rqt_new_sample, 1);
    tick();
    checkOutput("wd_err_sticky", timeout_err, 1);
    checkOutput("wd_no_sd", sd_count, 0);
    checkOutput("wd_no_gw", gw_count, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("wd_err_cleared", timeout_err, 0);
    tick();
  endtask
`endif

  initial begin
    logic [NS-1:0] pattern;
    rst         = 1'b1;
    trans_start = 1'b0;
    step_valid  = 1'b0;
    spk_in      = 1'b0;
    layer_done  = 1'b0;
    infer_ready = 1'b0;
    clearCounts();
    tick();
    tick();
    checkOutput("reset_rqt", rqt_new_sample, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_cnt", step_cnt, 0);
    checkOutput("reset_ls", layer_start, 0);
    checkOutput("reset_gw", get_winner, 0);
    checkOutput("reset_sd", sample_done, 0);
    checkOutput("reset_tmo", timeout_err, 0);
    rst = 1'b0;
    tick();
    checkOutput("post_reset_rqt", rqt_new_sample, 1);

    applyStimulus('1, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('1, 1'b1, 1'b0);
    applyStimulus(NS'(4'b0101), 1'b0, 1'b1);
    for (int n = 0; n < 8; n++) begin
      pattern = NS'($urandom);
      applyStimulus(pattern, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    resetMidLayer();
    applyStimulus(NS'(4'b1010), 1'b0, 1'b0);
`ifdef SNN_SEQ_WATCHDOG_EN
    watchdogCase();
    applyStimulus('1, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
